// File: rtl/scan_target_router.sv
// Routes single scan read/write requests to one of NUM_TGT targets selected by address MSBs.
// Optional WAIT timeout is compiled in with `define SCAN_ROUTER_TIMEOUT_EN.
module scan_target_router #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_TGT = 4,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned TO_CYC  = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      scan_ren,
  input  logic                      scan_wen,
  input  logic [ADDR_W-1:0]         scan_addr,
  input  logic [DATA_W-1:0]         scan_wdata,
  output logic [DATA_W-1:0]         scan_rdata,
  output logic                      scan_ready,
  output logic                      scan_err,
  output logic                      busy,
  output logic [NUM_TGT-1:0]        tgt_ren,
  output logic [NUM_TGT-1:0]        tgt_wen,
  output logic [ADDR_W-SEL_W-1:0]   tgt_addr,
  output logic [DATA_W-1:0]         tgt_wdata,
  input  logic [NUM_TGT*DATA_W-1:0] tgt_rdata,
  input  logic [NUM_TGT-1:0]        tgt_ready
);

  localparam int unsigned LocW = ADDR_W - SEL_W;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q;
  logic [LocW-1:0]     addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                ready_q;
  logic [NUM_TGT-1:0]  ren_q;
  logic [NUM_TGT-1:0]  wen_q;

  logic [SEL_W-1:0]    req_sel;
  logic                req;
  logic                req_bad;
  logic [NUM_TGT-1:0]  req_oh;
  logic                hit;
  logic [DATA_W-1:0]   hit_rdata;
  logic                timeout;

  assign req_sel = scan_addr[ADDR_W-1 -: SEL_W];
  assign req     = scan_ren | scan_wen;
  assign req_bad = (scan_ren & scan_wen) | (32'(req_sel) >= NUM_TGT);

  always_comb begin
    req_oh = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      req_oh[i] = (32'(req_sel) == i);
    end
  end

  // The active strobe doubles as the latched one-hot target index.
  assign hit = |(tgt_ready & (ren_q | wen_q));

  always_comb begin
    hit_rdata = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (ren_q[i] && tgt_ready[i]) begin
        hit_rdata = tgt_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef SCAN_ROUTER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TO_CYC);

  logic [CntW-1:0] cnt_q;

  // Counter sits at zero outside WAIT, so it is already clear on WAIT entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == StWait) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  assign timeout = (state_q == StWait) && (cnt_q == CntW'(TO_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      ren_q   <= '0;
      wen_q   <= '0;
    end else begin
      ready_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            addr_q  <= scan_addr[LocW-1:0];
            wdata_q <= scan_wen ? scan_wdata : '0;
            if (req_bad) begin
              state_q <= StResp;
              ready_q <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else begin
              state_q <= StWait;
              ren_q   <= scan_ren ? req_oh : '0;
              wen_q   <= scan_wen ? req_oh : '0;
            end
          end
        end
        StWait: begin
          // Ready in the same cycle as the timeout takes priority.
          if (hit) begin
            state_q <= StResp;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
            rdata_q <= hit_rdata;
            ren_q   <= '0;
            wen_q   <= '0;
          end else if (timeout) begin
            state_q <= StResp;
            ready_q <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= '0;
            ren_q   <= '0;
            wen_q   <= '0;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign scan_rdata = rdata_q;
  assign scan_err   = err_q;
  assign scan_ready = ready_q;
  assign busy       = (state_q != StIdle);
  assign tgt_ren    = ren_q;
  assign tgt_wen    = wen_q;
  assign tgt_addr   = addr_q;
  assign tgt_wdata  = wdata_q;

endmodule

// File: tb/tb_scan_target_router.sv
// Directed bench for scan_target_router: expected responses are queued at issue time and
// checked by an independent monitor on every scan_ready.
module tb_scan_target_router;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NT = 4;
  localparam int SW = 3;

  logic              clk;
  logic              rst_n;
  logic              scan_ren;
  logic              scan_wen;
  logic [AW-1:0]     scan_addr;
  logic [DW-1:0]     scan_wdata;
  logic [DW-1:0]     scan_rdata;
  logic              scan_ready;
  logic              scan_err;
  logic              busy;
  logic [NT-1:0]     tgt_ren;
  logic [NT-1:0]     tgt_wen;
  logic [AW-SW-1:0]  tgt_addr;
  logic [DW-1:0]     tgt_wdata;
  logic [NT*DW-1:0]  tgt_rdata;
  logic [NT-1:0]     tgt_ready;

  scan_target_router #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .NUM_TGT(NT),
    .SEL_W  (SW),
    .TO_CYC (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scan_ren  (scan_ren),
    .scan_wen  (scan_wen),
    .scan_addr (scan_addr),
    .scan_wdata(scan_wdata),
    .scan_rdata(scan_rdata),
    .scan_ready(scan_ready),
    .scan_err  (scan_err),
    .busy      (busy),
    .tgt_ren   (tgt_ren),
    .tgt_wen   (tgt_wen),
    .tgt_addr  (tgt_addr),
    .tgt_wdata (tgt_wdata),
    .tgt_rdata (tgt_rdata),
    .tgt_ready (tgt_ready)
  );

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every scan_ready must match the oldest queued expectation, including its cycle.
  always @(negedge clk) begin
    if (rst_n && scan_ready) begin
      if (q.size() == 0) begin
        check("unexpected_scan_ready", 64'(cyc), 64'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("resp_rdata", 64'(scan_rdata), 64'(e.rdata));
        check("resp_err", 64'(scan_err), 64'(e.err));
        check("resp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Request presented for exactly one cycle; t0 is the cycle it was presented in.
  task automatic issue(input logic ren, input logic wen, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, output int t0);
    @(posedge clk); #1;
    scan_ren = ren; scan_wen = wen; scan_addr = addr; scan_wdata = wdata;
    t0 = cyc;
    @(posedge clk); #1;
    scan_ren = 1'b0; scan_wen = 1'b0; scan_addr = '0; scan_wdata = '0;
  endtask

  // Pulse tgt_ready[idx] during cycle t0+d with the given read data on slice idx.
  task automatic respond(input int idx, input int t0, input int d, input logic [DW-1:0] rd);
    while (cyc < t0 + d) begin
      @(posedge clk); #1;
    end
    tgt_rdata[idx*DW +: DW] = rd;
    tgt_ready[idx] = 1'b1;
    @(posedge clk); #1;
    tgt_ready = '0;
  endtask

  task automatic push(input logic [DW-1:0] rd, input logic err, input int c);
    exp_t e;
    e.rdata = rd; e.err = err; e.cyc = c;
    q.push_back(e);
  endtask

  initial begin
    int t0;
    rst_n = 1'b0; scan_ren = 1'b0; scan_wen = 1'b0; scan_addr = '0; scan_wdata = '0;
    tgt_ready = '0;
    tgt_rdata = {32'hDDDD_0003, 32'hDEAD_BEEF, 32'hCCCC_0001, 32'hBBBB_0000};
    #23;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_scan_ready", 64'(scan_ready), 64'd0);
    check("rst_scan_err", 64'(scan_err), 64'd0);
    check("rst_scan_rdata", 64'(scan_rdata), 64'd0);
    check("rst_strobes", 64'({tgt_ren, tgt_wen}), 64'd0);
    check("rst_latched", 64'({tgt_addr, tgt_wdata}), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Write to target 1, ready during the third strobe cycle.
    issue(1'b0, 1'b1, 16'h2010, 32'hA5A5_5A5A, t0);
    @(negedge clk);
    check("wr_wen", 64'(tgt_wen), 64'b0010);
    check("wr_ren", 64'(tgt_ren), 64'd0);
    check("wr_addr", 64'(tgt_addr), 64'h0010);
    check("wr_wdata", 64'(tgt_wdata), 64'hA5A5_5A5A);
    check("wr_busy", 64'(busy), 64'd1);
    push(32'h0, 1'b0, t0 + 4);
    respond(1, t0, 3, 32'h0);
    @(negedge clk);
    check("wr_strobe_drop", 64'(tgt_wen), 64'd0);

    // Read from target 3, ready after 5 strobe cycles: scan_ready in cycle t0+6.
    issue(1'b1, 1'b0, 16'h6004, 32'hFFFF_FFFF, t0);
    @(negedge clk);
    check("rd_ren", 64'(tgt_ren), 64'b1000);
    check("rd_addr", 64'(tgt_addr), 64'h0004);
    check("rd_wdata_zero", 64'(tgt_wdata), 64'd0);
    push(32'h1234_5678, 1'b0, t0 + 6);
    respond(3, t0, 5, 32'h1234_5678);
    repeat (3) @(negedge clk);
    check("rd_rdata_held", 64'(scan_rdata), 64'h1234_5678);
    check("rd_idle", 64'(busy), 64'd0);

    // Out-of-range index and simultaneous read+write both error out without a strobe.
    issue(1'b1, 1'b0, 16'hE000, 32'h0, t0);
    push(32'h0, 1'b1, t0 + 1);
    @(negedge clk);
    check("bad_idx_strobes", 64'({tgt_ren, tgt_wen}), 64'd0);
    issue(1'b1, 1'b1, 16'h2000, 32'h55, t0);
    push(32'h0, 1'b1, t0 + 1);
    @(negedge clk);
    check("rdwr_strobes", 64'({tgt_ren, tgt_wen}), 64'd0);

    // Ready outside WAIT is ignored (monitor flags any response).
    @(posedge clk); #1; tgt_ready = '1;
    @(posedge clk); #1; tgt_ready = '0;
    @(negedge clk);
    check("idle_ready_ignored", 64'(busy), 64'd0);

    // Target-0 read: stray ready[2] and a second request mid-WAIT are ignored.
    issue(1'b1, 1'b0, 16'h0008, 32'h0, t0);
    tgt_ready[2] = 1'b1; scan_wen = 1'b1; scan_addr = 16'h2000; scan_wdata = 32'h77;
    @(posedge clk); #1;
    tgt_ready = '0; scan_wen = 1'b0; scan_addr = '0; scan_wdata = '0;
    @(negedge clk);
    check("stray_ren_kept", 64'(tgt_ren), 64'b0001);
    check("drop_req_no_wen", 64'(tgt_wen), 64'd0);
    check("drop_req_addr", 64'(tgt_addr), 64'h0008);
    push(32'hCAFE_F00D, 1'b0, t0 + 4);
    respond(0, t0, 3, 32'hCAFE_F00D);

    // Reset mid-WAIT clears the strobe asynchronously; no response follows.
    issue(1'b1, 1'b0, 16'h4000, 32'h0, t0);
    check("pre_rst_ren", 64'(tgt_ren), 64'b0100);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ren", 64'(tgt_ren), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_rdata", 64'(scan_rdata), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Fastest completion: ready in the first strobe cycle, scan_ready two cycles after request.
    issue(1'b0, 1'b1, 16'h2004, 32'h0BAD_CAFE, t0);
    push(32'h0, 1'b0, t0 + 2);
    respond(1, t0, 1, 32'h0);

`ifdef SCAN_ROUTER_TIMEOUT_EN
    // Target never ready: strobe held for 8 WAIT cycles, then error response.
    issue(1'b1, 1'b0, 16'h0000, 32'h0, t0);
    push(32'h0, 1'b1, t0 + 9);
    while (cyc < t0 + 8) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("to_strobe_c8", 64'(tgt_ren), 64'b0001);
    @(negedge clk);
    check("to_strobe_drop", 64'(tgt_ren), 64'd0);
    // Ready in the 8th WAIT cycle beats the timeout.
    issue(1'b1, 1'b0, 16'h0000, 32'h0, t0);
    push(32'h1111_2222, 1'b0, t0 + 9);
    respond(0, t0, 8, 32'h1111_2222);
`endif

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("all_responses_seen", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
